// File: rtl/l_next_mem.sv
// l_next_mem: behavioural next-level memory shared by N_CH cache channels.
// Round-robin arbitration, fixed-latency response, saturating access counters.
module l_next_mem #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH-1:0]        req_we,
  input  logic [N_CH*ADDR_W-1:0] req_addr,
  output logic [N_CH-1:0]        req_ready,
  output logic [N_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy,
  output logic [N_CH*CNT_W-1:0]  rd_count,
  output logic [N_CH*CNT_W-1:0]  wr_count
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_ch;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [LAT_W-1:0]    r_lat;
  logic [N_CH-1:0]     r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [CNT_W-1:0]    r_rd_cnt [N_CH];
  logic [CNT_W-1:0]    r_wr_cnt [N_CH];

  logic                w_found;
  logic [PTR_W-1:0]    w_gnt;
  logic                w_accept;
  logic                w_to_resp;
  logic                w_req_we;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [PTR_W-1:0]    w_ch_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_addr_ext;
  logic [N_CH-1:0]     w_rsp_vec;

  // Scan from the pointer upward, wrapping; first valid channel wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N_CH; i++) begin
      logic [SUM_W-1:0] v_sum;
      v_sum = {1'b0, r_ptr} + SUM_W'(i);
      if (v_sum >= SUM_W'(N_CH)) begin
        v_sum = v_sum - SUM_W'(N_CH);
      end
      if (!w_found && req_valid[v_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_sum[PTR_W-1:0];
      end
    end
  end

  assign w_req_we   = req_we[w_gnt];
  assign w_req_addr = req_addr[w_gnt*ADDR_W +: ADDR_W];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_to_resp   = 1'b0;
    req_ready   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (rst_n && w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
          w_to_resp        = (LATENCY == 1);
          w_state_nxt      = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == LAT_W'(1)) begin
          w_to_resp   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // With LATENCY=1 the response is loaded straight from the request.
  assign w_ch_nxt   = w_accept ? w_gnt : r_ch;
  assign w_we_nxt   = w_accept ? w_req_we : r_we;
  assign w_addr_nxt = w_accept ? w_req_addr : r_addr;

  generate
    if (ADDR_W >= DATA_W) begin : g_trunc
      assign w_addr_ext = w_addr_nxt[DATA_W-1:0];
    end else begin : g_zext
      assign w_addr_ext = {{(DATA_W-ADDR_W){1'b0}}, w_addr_nxt};
    end
  endgenerate

  always_comb begin
    w_rsp_vec           = '0;
    w_rsp_vec[w_ch_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_ch        <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_lat       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      if (w_accept) begin
        r_ch   <= w_gnt;
        r_we   <= w_req_we;
        r_addr <= w_req_addr;
        r_lat  <= LAT_W'(LATENCY - 1);
        r_ptr  <= (w_gnt == PTR_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
      end else if (r_state == S_WAIT) begin
        r_lat <= r_lat - 1'b1;
      end
      if (w_to_resp) begin
        r_rsp_valid <= w_rsp_vec;
        r_rsp_data  <= w_we_nxt ? '0 : w_addr_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rst_n) begin
        r_rd_cnt[i] <= '0;
        r_wr_cnt[i] <= '0;
      end else if (w_accept && w_gnt == PTR_W'(i)) begin
        if (w_req_we && r_wr_cnt[i] != '1) begin
          r_wr_cnt[i] <= r_wr_cnt[i] + 1'b1;
        end
        if (!w_req_we && r_rd_cnt[i] != '1) begin
          r_rd_cnt[i] <= r_rd_cnt[i] + 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign rd_count[g*CNT_W +: CNT_W] = r_rd_cnt[g];
      assign wr_count[g*CNT_W +: CNT_W] = r_wr_cnt[g];
    end
  endgenerate

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);

endmodule
